envm_fault_reader: RTL and testbench
====================================

ENVM_FAULT_READER -- requirements
Module: envm_fault_reader

Interface
REQ-001 Parameter SYSTOLIC_SIZE, default 8, array dimension N; number of eNVM rows and PE columns per row.
REQ-002 Parameter ADDR_WIDTH, default $clog2(SYSTOLIC_SIZE), eNVM row address width.
REQ-003 Parameter CNT_WIDTH, default $clog2(SYSTOLIC_SIZE)+1, width of faulty_count.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high. Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse that begins a readout.
- rd_en  output  1  eNVM read strobe.
- rd_addr  output  ADDR_WIDTH  eNVM row address.
- rd_pe_data  input  SYSTOLIC_SIZE  per-PE fault bits of the addressed row, valid 1 cycle after rd_en.
- rd_row_flag  input  1  row fault bit, same timing as rd_pe_data.
- faulty_patterns_flat  output  SYSTOLIC_SIZE*SYSTOLIC_SIZE  compacted fault patterns; slot k = bits [k*N +: N].
- faulty_row_addrs_flat  output  SYSTOLIC_SIZE*ADDR_WIDTH  row address for slot k = bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- faulty_valid_mask  output  SYSTOLIC_SIZE  bit k set = slot k holds a faulty row.
- faulty_count  output  CNT_WIDTH  number of valid slots.
- busy  output  1  readout in progress.
- done  output  1  one-cycle pulse when readout completes.

Function
REQ-005 FSM states IDLE, READ, DRAIN, DONE; reset state IDLE.
REQ-006 IDLE: start=1 -> READ; clears the pattern, address, valid-mask and count registers in that same edge; rd_addr=0.
REQ-007 READ: rd_en=1 and rd_addr increments by 1 each cycle from 0 to N-1; after addr N-1 is issued, go to DRAIN.
REQ-008 Read latency is fixed at 1 cycle; the response to address a is sampled on the edge after rd_en with rd_addr=a, tagged with a via a 1-deep address pipeline register.
REQ-009 A returned row is faulty if rd_row_flag=1 or any bit of rd_pe_data is 1.
REQ-010 For a faulty row: write rd_pe_data to slot faulty_count, write the tagged address to the same slot, set faulty_valid_mask[faulty_count], and increment faulty_count; fault-free rows write nothing.
REQ-011 Slots fill in ascending row order with no gaps; faulty_count never exceeds N (N faulty rows fill all slots).
REQ-012 A row with rd_row_flag=1 and rd_pe_data=0 stores pattern all-ones (whole row faulty).
REQ-013 DRAIN: rd_en=0; capture the last response (addr N-1); go to DONE.
REQ-014 DONE: done=1 for exactly one cycle; go to IDLE.
REQ-015 busy=1 in READ, DRAIN and DONE; 0 in IDLE.
REQ-016 start while busy=1 is ignored.
REQ-017 Result outputs hold their values from DONE until the next accepted start; a readout takes N+2 cycles from the start edge to the done cycle inclusive.
REQ-018 rd_en=0 and rd_addr=0 whenever state is not READ.

Reset
REQ-019 rst=1 at any edge, including mid-readout: state IDLE; all outputs 0 (rd_en, rd_addr, busy, done, faulty_count, faulty_valid_mask, faulty_patterns_flat, faulty_row_addrs_flat); any in-flight response is discarded.
REQ-020 Reset takes priority over start in the same cycle.

Configuration
REQ-021 Macro ENVM_COLUMN_MAP_EN: when defined, the block adds input rd_col_flag (1 bit, same timing as rd_pe_data) and output faulty_column_mask (SYSTOLIC_SIZE); bit a is set to rd_col_flag of row a; the mask is cleared on accepted start and on reset. When undefined, neither port exists and there is no column logic.

Verification
REQ-022 All rows clean, start -> done at cycle N+2, faulty_count=0, faulty_valid_mask=0x00, patterns=0.
REQ-023 N=8; row 2 pe=0x10, row 5 pe=0x81, others 0 -> count=2, mask=0x03, slot0={0x10,addr 2}, slot1={0x81,addr 5}.
REQ-024 All 8 rows pe=0x01 -> count=8, mask=0xFF, slot k address = k.
REQ-025 Row 7 row_flag=1, pe=0 -> slot0 pattern=0xFF, addr=7, count=1; start pulsed mid-run at cycle 3 is ignored, so there is a single done.
REQ-026 rst asserted at cycle 4 of a readout -> next cycle all outputs 0 and busy=0; a new start gives a full, correct readout.
REQ-027 With ENVM_COLUMN_MAP_EN defined, col_flag=1 on rows 1 and 6 -> faulty_column_mask=0x42.

Source files
------------

// File: rtl/envm_fault_reader.sv
// Reads every eNVM fault row once and packs the faulty rows into consecutive result slots.
// Define ENVM_COLUMN_MAP_EN to add rd_col_flag and the faulty_column_mask output.
module envm_fault_reader #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE) + 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   rd_en,
    output logic [ADDR_WIDTH-1:0]                  rd_addr,
    input  logic [SYSTOLIC_SIZE-1:0]               rd_pe_data,
    input  logic                                   rd_row_flag,
`ifdef ENVM_COLUMN_MAP_EN
    input  logic                                   rd_col_flag,
    output logic [SYSTOLIC_SIZE-1:0]               faulty_column_mask,
`endif
    output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] faulty_patterns_flat,
    output logic [SYSTOLIC_SIZE*ADDR_WIDTH-1:0]    faulty_row_addrs_flat,
    output logic [SYSTOLIC_SIZE-1:0]               faulty_valid_mask,
    output logic [CNT_WIDTH-1:0]                   faulty_count,
    output logic                                   busy,
    output logic                                   done
);

    localparam int N = SYSTOLIC_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [N-1:0]          r_pat [N];
    logic [ADDR_WIDTH-1:0] r_raddr [N];
    logic [N-1:0]          r_mask;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_start_ok;
    logic                  w_faulty;
    logic [N-1:0]          w_pattern;
`ifdef ENVM_COLUMN_MAP_EN
    logic [N-1:0]          r_col;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        rd_en   = 1'b0;
        rd_addr = '0;
        busy    = 1'b1;
        done    = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = READ;
            end
            READ: begin
                rd_en   = 1'b1;
                rd_addr = r_addr;
                if (r_addr == LAST_ADDR) w_next = DRAIN;
            end
            DRAIN: w_next = DONE;
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_faulty   = rd_row_flag || (|rd_pe_data);
    // A row flagged faulty with no PE bits set means the whole row is bad.
    assign w_pattern  = (|rd_pe_data) ? rd_pe_data : '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_pat       <= '{default: '0};
            r_raddr     <= '{default: '0};
            r_mask      <= '0;
            r_count     <= '0;
`ifdef ENVM_COLUMN_MAP_EN
            r_col       <= '0;
`endif
        end else begin
            r_pend      <= rd_en;
            r_pend_addr <= rd_addr;
            if (r_state == READ) r_addr <= r_addr + ADDR_WIDTH'(1);
            if (w_start_ok) begin
                r_addr  <= '0;
                r_pat   <= '{default: '0};
                r_raddr <= '{default: '0};
                r_mask  <= '0;
                r_count <= '0;
`ifdef ENVM_COLUMN_MAP_EN
                r_col   <= '0;
`endif
            end else if (r_pend) begin
                if (w_faulty) begin
                    for (int unsigned k = 0; k < N; k++) begin
                        if (CNT_WIDTH'(k) == r_count) begin
                            r_pat[k]   <= w_pattern;
                            r_raddr[k] <= r_pend_addr;
                            r_mask[k]  <= 1'b1;
                        end
                    end
                    r_count <= r_count + CNT_WIDTH'(1);
                end
`ifdef ENVM_COLUMN_MAP_EN
                r_col[r_pend_addr] <= rd_col_flag;
`endif
            end
        end
    end

    always_comb begin
        faulty_patterns_flat  = '0;
        faulty_row_addrs_flat = '0;
        for (int unsigned k = 0; k < N; k++) begin
            faulty_patterns_flat[k*N +: N]                   = r_pat[k];
            faulty_row_addrs_flat[k*ADDR_WIDTH +: ADDR_WIDTH] = r_raddr[k];
        end
    end

    assign faulty_valid_mask = r_mask;
    assign faulty_count      = r_count;
`ifdef ENVM_COLUMN_MAP_EN
    assign faulty_column_mask = r_col;
`endif

endmodule

// File: tb/tb_envm_fault_reader.sv
// Randomized check of envm_fault_reader against a row-list reference model.
// Column-map checks are included when ENVM_COLUMN_MAP_EN is defined.
module tb_envm_fault_reader;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [N-1:0]    rd_pe_data;
    logic            rd_row_flag;
    logic [N*N-1:0]  faulty_patterns_flat;
    logic [N*AW-1:0] faulty_row_addrs_flat;
    logic [N-1:0]    faulty_valid_mask;
    logic [CW-1:0]   faulty_count;
    logic            busy;
    logic            done;
`ifdef ENVM_COLUMN_MAP_EN
    logic            rd_col_flag;
    logic [N-1:0]    faulty_column_mask;
`endif

    envm_fault_reader #(.SYSTOLIC_SIZE(N), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .rd_en                 (rd_en),
        .rd_addr               (rd_addr),
        .rd_pe_data            (rd_pe_data),
        .rd_row_flag           (rd_row_flag),
`ifdef ENVM_COLUMN_MAP_EN
        .rd_col_flag           (rd_col_flag),
        .faulty_column_mask    (faulty_column_mask),
`endif
        .faulty_patterns_flat  (faulty_patterns_flat),
        .faulty_row_addrs_flat (faulty_row_addrs_flat),
        .faulty_valid_mask     (faulty_valid_mask),
        .faulty_count          (faulty_count),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clk = ~clk;

    // eNVM contents served to the DUT
    logic [N-1:0] m_pe [N];
    logic         m_rf [N];
    logic         m_cf [N];

    // expected results
    logic [N*N-1:0]  e_pat;
    logic [N*AW-1:0] e_addr;
    logic [N-1:0]    e_mask;
    logic [CW-1:0]   e_cnt;
    logic [N-1:0]    e_col;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // eNVM model: answers one cycle after rd_en, noise otherwise
    initial begin
        logic         en;
        logic [AW-1:0] a;
        rd_pe_data  = '0;
        rd_row_flag = 1'b0;
`ifdef ENVM_COLUMN_MAP_EN
        rd_col_flag = 1'b0;
`endif
        forever begin
            @(posedge clk);
            en = rd_en;
            a  = rd_addr;
            #1;
            if (en) begin
                rd_pe_data  = m_pe[a];
                rd_row_flag = m_rf[a];
`ifdef ENVM_COLUMN_MAP_EN
                rd_col_flag = m_cf[a];
`endif
            end else begin
                rd_pe_data  = N'($urandom);
                rd_row_flag = 1'($urandom);
`ifdef ENVM_COLUMN_MAP_EN
                rd_col_flag = 1'($urandom);
`endif
            end
        end
    end

    task automatic clear_mem();
        for (int a = 0; a < N; a++) begin
            m_pe[a] = '0;
            m_rf[a] = 1'b0;
            m_cf[a] = 1'b0;
        end
    endtask

    task automatic random_mem();
        int density;
        density = $urandom_range(0, 4);
        for (int a = 0; a < N; a++) begin
            m_pe[a] = '0;
            m_rf[a] = 1'b0;
            m_cf[a] = 1'($urandom);
            if ($urandom_range(0, 3) < density) begin
                case ($urandom_range(0, 2))
                    0: begin m_pe[a] = N'($urandom); if (m_pe[a] == '0) m_pe[a] = 8'h01; end
                    1: m_rf[a] = 1'b1;
                    default: begin m_pe[a] = N'($urandom); m_rf[a] = 1'b1; end
                endcase
            end
        end
    endtask

    // Walk the rows in order and append each faulty one to the next free slot
    task automatic compute_expected();
        int slot;
        slot   = 0;
        e_pat  = '0;
        e_addr = '0;
        e_mask = '0;
        e_col  = '0;
        for (int a = 0; a < N; a++) begin
            if (m_rf[a] || m_pe[a] != 0) begin
                e_pat[slot*N +: N]   = (m_pe[a] == 0) ? 8'hFF : m_pe[a];
                e_addr[slot*AW +: AW] = AW'(a);
                e_mask[slot]         = 1'b1;
                slot++;
            end
            e_col[a] = m_cf[a];
        end
        e_cnt = CW'(slot);
    endtask

    task automatic check_results(input string tag);
        check({tag, ".count"}, 64'(faulty_count), 64'(e_cnt));
        check({tag, ".mask"},  64'(faulty_valid_mask), 64'(e_mask));
        check({tag, ".pat"},   64'(faulty_patterns_flat), 64'(e_pat));
        check({tag, ".addr"},  64'(faulty_row_addrs_flat), 64'(e_addr));
`ifdef ENVM_COLUMN_MAP_EN
        check({tag, ".col"},   64'(faulty_column_mask), 64'(e_col));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rd_en"},   64'(rd_en), 64'(0));
        check({tag, ".rd_addr"}, 64'(rd_addr), 64'(0));
        check({tag, ".busy"},    64'(busy), 64'(0));
        check({tag, ".done"},    64'(done), 64'(0));
        check({tag, ".count"},   64'(faulty_count), 64'(0));
        check({tag, ".mask"},    64'(faulty_valid_mask), 64'(0));
        check({tag, ".pat"},     64'(faulty_patterns_flat), 64'(0));
        check({tag, ".addr"},    64'(faulty_row_addrs_flat), 64'(0));
`ifdef ENVM_COLUMN_MAP_EN
        check({tag, ".col"},     64'(faulty_column_mask), 64'(0));
`endif
    endtask

    // Called at a negedge in IDLE. Cycle c counts cycles after the start edge.
    task automatic run_readout(input string tag, input int mid_start, input int rst_cycle);
        compute_expected();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= N + 2; c++) begin
            check({tag, ".seq_rd_en"},   64'(rd_en), 64'(c <= N));
            check({tag, ".seq_rd_addr"}, 64'(rd_addr), 64'((c <= N) ? c - 1 : 0));
            check({tag, ".seq_busy"},    64'(busy), 64'(1));
            check({tag, ".seq_done"},    64'(done), 64'(c == N + 2));
            start = (c == mid_start);
            if (c == rst_cycle) begin
                rst = 1'b1;
                @(negedge clk);
                check_all_zero({tag, ".rst"});
                rst   = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check_all_zero({tag, ".post_rst"});
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".idle_busy"}, 64'(busy), 64'(0));
        check_results(tag);
        repeat (3) begin
            @(negedge clk);
            check({tag, ".no_2nd_done"}, 64'(done), 64'(0));
            check({tag, ".idle_rd_en"},  64'(rd_en), 64'(0));
        end
        check_results({tag, ".hold"});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        start = 1'b1;
        @(negedge clk);
        check_all_zero("reset_over_start");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        clear_mem();
        run_readout("all_clean", 0, 0);

        clear_mem();
        m_pe[2] = 8'h10;
        m_pe[5] = 8'h81;
`ifdef ENVM_COLUMN_MAP_EN
        m_cf[1] = 1'b1;
        m_cf[6] = 1'b1;
`endif
        run_readout("two_rows", 0, 0);
`ifdef ENVM_COLUMN_MAP_EN
        check("col_map_0x42", 64'(faulty_column_mask), 64'h42);
`endif

        clear_mem();
        for (int a = 0; a < N; a++) m_pe[a] = 8'h01;
        run_readout("all_faulty", 0, 0);

        clear_mem();
        m_rf[7] = 1'b1;
        run_readout("row_flag_mid_start", 3, 0);

        random_mem();
        run_readout("pre_rst", 0, 0);
        random_mem();
        run_readout("mid_rst", 0, 4);
        random_mem();
        run_readout("after_mid_rst", 0, 0);

        for (int i = 0; i < 25; i++) begin
            random_mem();
            run_readout($sformatf("rand%0d", i), (i % 3 == 0) ? $urandom_range(1, N + 1) : 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
